regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the CPU core's register file between NUM_REQ writeback sources (e.g. ALU writeback, load unit, CSR unit) using round-robin arbitration behind a one-stage registered output. It also keeps a pending-write scoreboard, one busy bit per architectural register, so the issue stage can stall on read-after-write hazards. It sits between the writeback sources and the register file's write port (i_we/i_waddr/i_wdata).

## Interface
- NUM_REQ, 3: number of writeback requesters (2..8)
- XLEN, cotm32_pkg::XLEN (32): data width
- NUM_REGS, cotm32_pkg::NUM_REGS (32): architectural registers; AW = $clog2(NUM_REGS)

Ports:
- i_clk  in  1  core clock; all state updates on posedge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_REQ  per-requester write request
- i_req_addr  in  NUM_REQ×AW  destination register per requester
- i_req_data  in  NUM_REQ×XLEN  write data per requester
- o_req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
- o_we  out  1  to register file write enable
- o_waddr  out  AW  to register file write address
- o_wdata  out  XLEN  to register file write data
- i_claim_valid  in  1  issue stage reserves a destination register
- i_claim_addr  in  AW  register being reserved
- o_busy  out  NUM_REGS  scoreboard; bit r = write to xr pending
- o_claim_err  out  1  sticky; claim issued to an already-busy register

## Operation
- Arbitration: round-robin pointer ptr (0..NUM_REQ-1). Grant the first valid requester searching ptr, ptr+1, … modulo NUM_REQ. At most one o_req_ready bit is set. o_req_ready is combinational from i_req_valid and ptr. It never asserts for a non-valid requester.
- The output stage always drains, so a valid request is never blocked except by losing arbitration.
- On a transfer by requester k: ptr <= (k+1) mod NUM_REQ. With no transfer, ptr holds.
- Output register: on a transfer, o_we <= (addr != 0), o_waddr <= addr, o_wdata <= data. With no transfer, o_we <= 0 and o_waddr/o_wdata hold.
- Writes to x0 are accepted (ready asserted) and dropped: o_we stays 0.
- Scoreboard:
  - On i_claim_valid with addr != 0, busy[addr] is set.
  - When o_we = 1, busy[o_waddr] is cleared on the same edge that the register file commits the write.
  - busy[0] is always 0.
- Simultaneous claim and clear of the same register on the same edge: the claim wins and the bit stays 1, because a new writer is now in flight.
- A claim to a register whose busy bit is already 1 (without a same-edge clear) sets o_claim_err = 1. It stays set until reset. The busy bit stays 1 and is not a counter.
- Requesters are required to hold valid, addr and data stable until accepted. The arbiter does not check this.

## Timing
- Reset (asynchronous assert, synchronous to i_clk on deassert):
  - o_we = 0, o_waddr = 0, o_wdata = 0
  - o_busy = 0, o_claim_err = 0, ptr = 0
  - o_req_ready = 0 while i_rst_n = 0
- Latency: a transfer in cycle N gives o_we = 1 during cycle N+1. The register file updates at the end of N+1, and the busy bit clears at that same edge. The register file's write-through forwarding covers reads in N+1.
- Throughput: one write per cycle. Back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Reset asserted mid-operation: any pending output write is discarded (o_we drops immediately) and all busy bits clear. Requests in flight are lost, and upstream is reset by the same signal.
- Claim to busy: a claim in cycle N is visible on o_busy in cycle N+1.

## Test plan
- Reset, then req0 valid (x5, 0xDEADBEEF) alone → ready0 = 1 in cycle 0; o_we = 1, o_waddr = 5, o_wdata = 0xDEADBEEF in cycle 1; ptr = 1.
- All three requesters valid continuously for 6 cycles → grants 0, 1, 2, 0, 1, 2; exactly one ready per cycle; o_we high for 6 consecutive cycles, starting one cycle late.
- req1 writes x0 with 0x1234 → ready1 = 1, o_we stays 0, o_busy unchanged.
- Claim x7 (busy[7] = 1 next cycle), then req2 writes x7 → busy[7] clears on the edge ending the o_we = 1 cycle. Repeat with a claim of x7 in that same cycle → busy[7] stays 1, o_claim_err = 0.
- Claim x3 twice without an intervening write → o_claim_err = 1 and stays set; a later write to x3 clears busy[3] but not o_claim_err.
- Assert i_rst_n = 0 mid-cycle while o_we = 1 and busy = 0x0000_0088 → o_we, o_busy, o_claim_err and o_req_ready go to 0 immediately without a clock edge; after release, the first grant goes to req0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a registered
// write stage and a per-register pending-write scoreboard for hazard stalls.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*AW-1:0]   i_req_addr,
  input  logic [NUM_REQ*XLEN-1:0] i_req_data,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic                    o_we,
  output logic [AW-1:0]           o_waddr,
  output logic [XLEN-1:0]         o_wdata,
  input  logic                    i_claim_valid,
  input  logic [AW-1:0]           i_claim_addr,
  output logic [NUM_REGS-1:0]     o_busy,
  output logic                    o_claim_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_nxt;
  logic [PW:0]         cand_sum;
  logic [PW:0]         nxt_sum;
  logic [PW-1:0]       cand;
  logic [NUM_REQ-1:0]  gnt_vec;
  logic                gnt_any;
  logic [PW-1:0]       gnt_idx;
  logic [AW-1:0]       sel_addr_p0;
  logic [XLEN-1:0]     sel_data_p0;

  logic                vld_p1;
  logic [AW-1:0]       waddr_p1;
  logic [XLEN-1:0]     wdata_p1;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                claim_conflict;
  logic                claim_err_q;

  // Stage p0: round-robin search starting at ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_vec     = '0;
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand_sum >= (PW+1)'(NUM_REQ))
        cand_sum = cand_sum - (PW+1)'(NUM_REQ);
      cand = cand_sum[PW-1:0];
      if (!gnt_any && i_req_valid[cand]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand;
        gnt_vec[cand] = 1'b1;
        sel_addr_p0   = i_req_addr[cand*AW +: AW];
        sel_data_p0   = i_req_data[cand*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    nxt_sum = {1'b0, gnt_idx} + (PW+1)'(1);
    if (nxt_sum >= (PW+1)'(NUM_REQ))
      nxt_sum = '0;
    ptr_nxt = nxt_sum[PW-1:0];
  end

  assign o_req_ready = i_rst_n ? gnt_vec : '0;

  // A claim landing on the same edge as the clear wins: a new writer is in flight.
  always_comb begin
    busy_nxt       = busy_q;
    claim_conflict = 1'b0;
    if (vld_p1)
      busy_nxt[waddr_p1] = 1'b0;
    if (i_claim_valid && (i_claim_addr != '0)) begin
      busy_nxt[i_claim_addr] = 1'b1;
      claim_conflict = busy_q[i_claim_addr] && !(vld_p1 && (waddr_p1 == i_claim_addr));
    end
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered register-file write port and scoreboard state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      vld_p1      <= 1'b0;
      waddr_p1    <= '0;
      wdata_p1    <= '0;
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr_q    <= ptr_nxt;
        vld_p1   <= (sel_addr_p0 != '0);
        waddr_p1 <= sel_addr_p0;
        wdata_p1 <= sel_data_p0;
      end else begin
        vld_p1   <= 1'b0;
      end
      busy_q <= busy_nxt;
      if (claim_conflict)
        claim_err_q <= 1'b1;
    end
  end

  assign o_we        = vld_p1;
  assign o_waddr     = waddr_p1;
  assign o_wdata     = wdata_p1;
  assign o_busy      = busy_q;
  assign o_claim_err = claim_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: constant vector table, directed scoreboard
// sequences, and randomized traffic checked against a cycle-level model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*XL-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XL-1:0]   wdata;
  logic            claim_valid;
  logic [AW-1:0]   claim_addr;
  logic [NR-1:0]   busy;
  logic            claim_err;

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .NUM_REGS(NR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(req_ready),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .i_claim_valid(claim_valid), .i_claim_addr(claim_addr),
    .o_busy(busy), .o_claim_err(claim_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // stimulus for the next cycle
  logic [N-1:0]  tv;
  logic [AW-1:0] ta [N];
  logic [XL-1:0] td [N];
  logic          tcv;
  logic [AW-1:0] tca;

  // reference model state
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [XL-1:0] m_wdata;
  logic [NR-1:0] m_busy;
  logic          m_err;

  // observations of the last cycle
  logic [N-1:0]  obs_ready;
  logic          obs_we;
  logic [AW-1:0] obs_waddr;
  logic [XL-1:0] obs_wdata;
  int            last_g;

  typedef struct {
    logic [N-1:0]  v;
    logic [AW-1:0] a0, a1, a2;
    logic [XL-1:0] d0, d1, d2;
    logic [N-1:0]  ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [XL-1:0] wdata;
  } vec_t;

  vec_t tbl [12];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_err = 1'b0;
  endtask

  task automatic set_in(logic [N-1:0] v, logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2,
                        logic [XL-1:0] d0, logic [XL-1:0] d1, logic [XL-1:0] d2,
                        logic cv, logic [AW-1:0] ca);
    tv = v; ta[0] = a0; ta[1] = a1; ta[2] = a2;
    td[0] = d0; td[1] = d1; td[2] = d2; tcv = cv; tca = ca;
  endtask

  task automatic idle(logic cv, logic [AW-1:0] ca);
    set_in('0, '0, '0, '0, '0, '0, '0, cv, ca);
  endtask

  // One clock cycle: called and returns at a falling edge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_r;
    req_valid   = tv;
    req_addr    = {ta[2], ta[1], ta[0]};
    req_data    = {td[2], td[1], td[0]};
    claim_valid = tcv;
    claim_addr  = tca;
    #1;
    g = model_grant(tv);
    exp_r = '0;
    if (g >= 0) exp_r[g] = 1'b1;
    obs_ready = req_ready;
    check("ready", 64'(req_ready), 64'(exp_r));
    @(posedge clk);
    if (tcv && tca != 0 && m_busy[tca] && !(m_we && m_waddr == tca)) m_err = 1'b1;
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (tcv && tca != 0) m_busy[tca] = 1'b1;
    if (g >= 0) begin
      m_we = (ta[g] != 0); m_waddr = ta[g]; m_wdata = td[g]; m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    #1;
    obs_we = we; obs_waddr = waddr; obs_wdata = wdata;
    check("we", 64'(we), 64'(m_we));
    check("waddr", 64'(waddr), 64'(m_waddr));
    check("wdata", 64'(wdata), 64'(m_wdata));
    check("busy", 64'(busy), 64'(m_busy));
    check("claim_err", 64'(claim_err), 64'(m_err));
    last_g = g;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '1; req_addr = '0; req_data = '0; claim_valid = 1'b0; claim_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(we), 64'(0));
    check("rst_waddr", 64'(waddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_claim_err", 64'(claim_err), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  logic          pv [N];
  logic [AW-1:0] pa [N];
  logic [XL-1:0] pd [N];

  initial begin
    tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 3'b001, 1'b1, 5'd1, 32'h0A0A0A0A};
    tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 3'b010, 1'b1, 5'd2, 32'h0B0B0B0B};
    tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 3'b100, 1'b1, 5'd3, 32'h0C0C0C0C};
    tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 3'b001, 1'b1, 5'd1, 32'h0A0A0A0A};
    tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 3'b010, 1'b1, 5'd2, 32'h0B0B0B0B};
    tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 3'b100, 1'b1, 5'd3, 32'h0C0C0C0C};
    tbl[6]  = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[7]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[8]  = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 3'b010, 1'b0, 5'd0, 32'h1234};
    tbl[9]  = '{3'b101, 5'd8, 5'd0, 5'd9, 32'h88, 32'h0, 32'h99, 3'b100, 1'b1, 5'd9, 32'h99};
    tbl[10] = '{3'b110, 5'd0, 5'd4, 5'd10, 32'h0, 32'h44, 32'hAA, 3'b010, 1'b1, 5'd4, 32'h44};
    tbl[11] = '{3'b011, 5'd6, 5'd11, 5'd0, 32'h66, 32'hBB, 32'h0, 3'b001, 1'b1, 5'd6, 32'h66};

    rst_n = 1'b0;
    model_reset();
    idle(1'b0, '0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2, 1'b0, '0);
      cycle();
      check($sformatf("tbl%0d_ready", i), 64'(obs_ready), 64'(tbl[i].ready));
      check($sformatf("tbl%0d_we", i), 64'(obs_we), 64'(tbl[i].we));
      check($sformatf("tbl%0d_waddr", i), 64'(obs_waddr), 64'(tbl[i].waddr));
      check($sformatf("tbl%0d_wdata", i), 64'(obs_wdata), 64'(tbl[i].wdata));
    end

    // claim x7, write it back, then a same-edge re-claim
    idle(1'b1, 5'd7); cycle();
    check("x7_claimed", 64'(busy[7]), 64'(1));
    set_in(3'b100, '0, '0, 5'd7, '0, '0, 32'h77, 1'b0, '0); cycle();
    check("x7_ready2", 64'(obs_ready), 64'(3'b100));
    check("x7_we", 64'(obs_we), 64'(1));
    check("x7_busy_during_we", 64'(busy[7]), 64'(1));
    idle(1'b0, '0); cycle();
    check("x7_cleared", 64'(busy[7]), 64'(0));
    idle(1'b1, 5'd7); cycle();
    set_in(3'b100, '0, '0, 5'd7, '0, '0, 32'h78, 1'b0, '0); cycle();
    idle(1'b1, 5'd7); cycle();
    check("x7_reclaim_busy", 64'(busy[7]), 64'(1));
    check("x7_reclaim_noerr", 64'(claim_err), 64'(0));
    set_in(3'b100, '0, '0, 5'd7, '0, '0, 32'h79, 1'b0, '0); cycle();
    idle(1'b0, '0); cycle();
    check("x7_final_clear", 64'(busy[7]), 64'(0));

    // double claim of x3 is sticky
    idle(1'b1, 5'd3); cycle();
    idle(1'b1, 5'd3); cycle();
    check("x3_err", 64'(claim_err), 64'(1));
    set_in(3'b001, 5'd3, '0, '0, 32'h33, '0, '0, 1'b0, '0); cycle();
    idle(1'b0, '0); cycle();
    check("x3_cleared", 64'(busy[3]), 64'(0));
    check("x3_err_sticky", 64'(claim_err), 64'(1));

    // asynchronous reset while a write is on the port
    do_reset();
    idle(1'b1, 5'd3); cycle();
    idle(1'b1, 5'd3); cycle();
    idle(1'b1, 5'd7); cycle();
    set_in(3'b001, 5'd1, '0, '0, 32'h11, '0, '0, 1'b0, '0); cycle();
    check("pre_rst_we", 64'(we), 64'(1));
    check("pre_rst_busy", 64'(busy), 64'(32'h88));
    check("pre_rst_err", 64'(claim_err), 64'(1));
    req_valid = 3'b111;
    claim_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_we", 64'(we), 64'(0));
    check("async_busy", 64'(busy), 64'(0));
    check("async_err", 64'(claim_err), 64'(0));
    check("async_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_in(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, '0); cycle();
    check("post_rst_grant0", 64'(obs_ready), 64'(3'b001));

    // randomized traffic with requests held until accepted
    for (int k = 0; k < N; k++) begin pv[k] = 1'b0; pa[k] = '0; pd[k] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pv[k] && $urandom_range(0, 2) != 0) begin
          pv[k] = 1'b1;
          pa[k] = AW'($urandom_range(0, 31));
          pd[k] = $urandom;
        end
      end
      set_in({pv[2], pv[1], pv[0]}, pa[0], pa[1], pa[2], pd[0], pd[1], pd[2],
             ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)));
      cycle();
      if (last_g >= 0) pv[last_g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
